// File: rtl/immediate_materializer.sv
// immediate_materializer
//   Encodes a 32-bit constant into the shortest MIPS sequence that loads it
//   into register rt: a single ori, addiu or lui, or the pair lui + ori. When
//   rt is zero the sequence is a single nop. Requests arrive on a valid/ready
//   handshake. Instruction words leave one per beat on a second valid/ready
//   handshake.
//
// Parameters
//   USE_ADDIU   1: values that sign-extend from 16 bits use addiu
//   PAD_TO_TWO  1: single-word forms (except the rt==0 nop) get a trailing nop
//
// Ports
//   i_clk, i_rst_n              clock; asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake (i_value, i_rt)
//   o_instr_valid/i_instr_ready instruction handshake (o_instr, o_instr_last)
//   o_busy                      high whenever a sequence is in progress
module immediate_materializer #(
    parameter bit USE_ADDIU  = 1'b1,
    parameter bit PAD_TO_TWO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_value,
    input  logic [4:0]  i_rt,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic        o_instr_last,
    output logic        o_busy
);

    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        IDLE,
        EMIT1,
        EMIT2
    } state_t;

    state_t      state;
    logic [31:0] word2_q;

    // Encoding of the incoming request. Both words are computed up front and
    // latched on accept, so the request value and rt need not be kept.
    logic [31:0] enc_w1;
    logic [31:0] enc_w2;
    logic        enc_two;
    logic        enc_pair;

    always_comb begin
        enc_w1   = 32'h0;
        enc_w2   = 32'h0;
        enc_pair = 1'b0;
        if (i_rt == 5'd0) begin
            enc_w1 = 32'h0;
        end else if (i_value[31:16] == 16'h0) begin
            enc_w1 = {OP_ORI, 5'd0, i_rt, i_value[15:0]};
        end else if (USE_ADDIU && (&i_value[31:15])) begin
            enc_w1 = {OP_ADDIU, 5'd0, i_rt, i_value[15:0]};
        end else if (i_value[15:0] == 16'h0) begin
            enc_w1 = {OP_LUI, 5'd0, i_rt, i_value[31:16]};
        end else begin
            enc_w1   = {OP_LUI, 5'd0, i_rt, i_value[31:16]};
            enc_w2   = {OP_ORI, i_rt, i_rt, i_value[15:0]};
            enc_pair = 1'b1;
        end
        // The rt==0 nop is never padded; padding word for other forms is a nop.
        enc_two = enc_pair | (PAD_TO_TWO && (i_rt != 5'd0));
    end

    // While in EMIT1, o_instr_last already tells whether a second word follows.
    // NOTE: every register below uses <= so all state updates see the values
    // from before the clock edge, regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_req_ready   <= 1'b1;
            o_instr_valid <= 1'b0;
            o_instr       <= 32'h0;
            o_instr_last  <= 1'b0;
            o_busy        <= 1'b0;
            word2_q       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        state         <= EMIT1;
                        o_req_ready   <= 1'b0;
                        o_busy        <= 1'b1;
                        o_instr_valid <= 1'b1;
                        o_instr       <= enc_w1;
                        o_instr_last  <= ~enc_two;
                        word2_q       <= enc_w2;
                    end
                end
                EMIT1: begin
                    if (i_instr_ready) begin
                        if (!o_instr_last) begin
                            state        <= EMIT2;
                            o_instr      <= word2_q;
                            o_instr_last <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            o_req_ready   <= 1'b1;
                            o_busy        <= 1'b0;
                            o_instr_valid <= 1'b0;
                            o_instr       <= 32'h0;
                            o_instr_last  <= 1'b0;
                        end
                    end
                end
                EMIT2: begin
                    if (i_instr_ready) begin
                        state         <= IDLE;
                        o_req_ready   <= 1'b1;
                        o_busy        <= 1'b0;
                        o_instr_valid <= 1'b0;
                        o_instr       <= 32'h0;
                        o_instr_last  <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_req_ready   <= 1'b1;
                    o_busy        <= 1'b0;
                    o_instr_valid <= 1'b0;
                    o_instr       <= 32'h0;
                    o_instr_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immediate_materializer.sv
// Testbench for immediate_materializer. Three instances cover the parameter
// combinations: [0] USE_ADDIU=1 PAD=0, [1] USE_ADDIU=0 PAD=0, [2] USE_ADDIU=1 PAD=1.
module tb_immediate_materializer;

    localparam bit UA [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit PD [3] = '{1'b0, 1'b0, 1'b1};

    logic        clk;
    logic        rst_n;
    logic        req_valid   [3];
    logic        req_ready   [3];
    logic [31:0] value       [3];
    logic [4:0]  rt_in       [3];
    logic        instr_valid [3];
    logic        instr_ready [3];
    logic [31:0] instr       [3];
    logic        last        [3];
    logic        busy        [3];

    int n_cmp = 0;
    int n_mis = 0;

    immediate_materializer #(.USE_ADDIU(1'b1), .PAD_TO_TWO(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_value(value[0]), .i_rt(rt_in[0]),
        .o_instr_valid(instr_valid[0]), .i_instr_ready(instr_ready[0]),
        .o_instr(instr[0]), .o_instr_last(last[0]), .o_busy(busy[0])
    );

    immediate_materializer #(.USE_ADDIU(1'b0), .PAD_TO_TWO(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_value(value[1]), .i_rt(rt_in[1]),
        .o_instr_valid(instr_valid[1]), .i_instr_ready(instr_ready[1]),
        .o_instr(instr[1]), .o_instr_last(last[1]), .o_busy(busy[1])
    );

    immediate_materializer #(.USE_ADDIU(1'b1), .PAD_TO_TWO(1'b1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
        .i_value(value[2]), .i_rt(rt_in[2]),
        .o_instr_valid(instr_valid[2]), .i_instr_ready(instr_ready[2]),
        .o_instr(instr[2]), .o_instr_last(last[2]), .o_busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: which instruction words load v into rt, straight from the
    // selection table. Returns the number of words.
    function automatic int model(input bit ua, input bit pad, input logic [31:0] v,
                                 input logic [4:0] rt,
                                 output logic [31:0] w0, output logic [31:0] w1);
        logic [15:0] hi;
        logic [15:0] lo;
        int          n;
        hi = v[31:16];
        lo = v[15:0];
        w1 = 32'h0;
        n  = 1;
        if (rt == 0) begin
            w0 = 32'h0;
            return 1;
        end
        if (hi == 16'h0)
            w0 = (32'h0D << 26) | (32'(rt) << 16) | 32'(lo);
        else if (ua && hi == 16'hFFFF && lo[15])
            w0 = (32'h09 << 26) | (32'(rt) << 16) | 32'(lo);
        else if (lo == 16'h0)
            w0 = (32'h0F << 26) | (32'(rt) << 16) | 32'(hi);
        else begin
            w0 = (32'h0F << 26) | (32'(rt) << 16) | 32'(hi);
            w1 = (32'h0D << 26) | (32'(rt) << 21) | (32'(rt) << 16) | 32'(lo);
            n  = 2;
        end
        if (pad) n = 2;
        return n;
    endfunction

    // One full request on instance k. The consumer holds ready low for
    // 'stall' cycles, then accepts with probability pct percent per cycle.
    task automatic do_req(input int k, input logic [31:0] v, input logic [4:0] rt,
                          input int stall, input int pct);
        logic [31:0] w0, w1, exp_w;
        int          n, idx, cyc;
        bit          rdy;
        n = model(UA[k], PD[k], v, rt, w0, w1);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready[k]), 32'd1);
        check("busy_idle", 32'(busy[k]), 32'd0);
        req_valid[k]   = 1'b1;
        value[k]       = v;
        rt_in[k]       = rt;
        instr_ready[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        value[k]     = $urandom;
        rt_in[k]     = 5'($urandom);
        check("valid_after_accept", 32'(instr_valid[k]), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            exp_w = (idx == 0) ? w0 : w1;
            check("instr", instr[k], exp_w);
            check("last", 32'(last[k]), 32'(idx == n - 1));
            check("valid", 32'(instr_valid[k]), 32'd1);
            check("req_ready_busy", 32'(req_ready[k]), 32'd0);
            check("busy", 32'(busy[k]), 32'd1);
            rdy = (cyc >= stall) && ($urandom_range(1, 100) <= pct);
            instr_ready[k] = rdy;
            @(posedge clk);
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        check("timeout", idx, n);
        instr_ready[k] = 1'b0;
        check("valid_done", 32'(instr_valid[k]), 32'd0);
        check("req_ready_done", 32'(req_ready[k]), 32'd1);
        check("busy_done", 32'(busy[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  rt;
        int          k;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]   = 1'b0;
            value[i]       = 32'h0;
            rt_in[i]       = 5'd0;
            instr_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check("rst_valid", 32'(instr_valid[i]), 32'd0);
            check("rst_instr", instr[i], 32'd0);
            check("rst_last", 32'(last[i]), 32'd0);
            check("rst_busy", 32'(busy[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Directed cases
        do_req(0, 32'h0000_1234, 5'd8, 0, 100);
        do_req(0, 32'hFFFF_FFFE, 5'd9, 0, 100);
        do_req(1, 32'hFFFF_FFFE, 5'd9, 0, 100);
        do_req(0, 32'h0000_8000, 5'd8, 0, 100);
        do_req(0, 32'h1234_0000, 5'd10, 0, 100);
        do_req(0, 32'hDEAD_BEEF, 5'd4, 3, 100);
        do_req(2, 32'h0000_0007, 5'd2, 0, 100);
        do_req(2, 32'hCAFE_F00D, 5'd0, 0, 100);
        do_req(1, 32'hFFFF_8000, 5'd3, 1, 100);
        do_req(0, 32'hFFFF_7FFF, 5'd31, 0, 100);

        // Reset in the middle of a two-word sequence
        @(negedge clk);
        req_valid[0] = 1'b1;
        value[0]     = 32'hDEAD_BEEF;
        rt_in[0]     = 5'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid[0]   = 1'b0;
        instr_ready[0] = 1'b1;
        check("mid_w1", instr[0], 32'h3C04_DEAD);
        @(posedge clk);
        @(negedge clk);
        instr_ready[0] = 1'b0;
        check("mid_w2", instr[0], 32'h3484_BEEF);
        check("mid_valid", 32'(instr_valid[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(instr_valid[0]), 32'd0);
        check("async_req_ready", 32'(req_ready[0]), 32'd1);
        check("async_busy", 32'(busy[0]), 32'd0);
        check("async_last", 32'(last[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);
        check("post_rst_valid", 32'(instr_valid[0]), 32'd0);
        do_req(0, 32'hDEAD_BEEF, 5'd4, 0, 100);

        // Randomized requests with category-biased values
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 2);
            case ($urandom_range(0, 4))
                0: v = $urandom;
                1: v = {16'h0, 16'($urandom)};
                2: v = {16'hFFFF, 1'b1, 15'($urandom)};
                3: v = {16'($urandom), 16'h0};
                default: v = {16'hFFFF, 16'($urandom)};
            endcase
            rt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            do_req(k, v, rt, $urandom_range(0, 2), $urandom_range(30, 100));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
